zap_wb_slave_mem: RTL and testbench

ZAP_WB_SLAVE_MEM -- requirements
Module: zap_wb_slave_mem

---
 rtl/zap_wb_slave_mem_pkg.sv | 25 ++
 rtl/zap_be_ram.sv | 33 +++
 rtl/zap_wb_slave_mem.sv | 144 ++++++++++++++
 tb/tb_zap_wb_slave_mem.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_slave_mem_pkg.sv
// Shared definitions for the Wishbone slave memory: cycle-type codes, FSM states
// and the address range check.
package zap_wb_slave_mem_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_BURST   = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAck,
      StBurst
   } zap_wb_state_e;

   // An address below the base (subtraction underflow) is out of range too.
   function automatic logic addr_out_of_range(input logic [31:0] adr,
                                              input logic [31:0] base,
                                              input logic [31:0] depth_words);
      logic [31:0] off;
      off = adr - base;
      return (adr < base) || ((off >> 2) >= depth_words);
   endfunction

endpackage

// File: rtl/zap_be_ram.sv
// Word-wide RAM with byte-lane writes and a registered read port.
// A read and a write to the same word in one cycle return the old contents.
module zap_be_ram #(
   parameter int unsigned Depth = 1024,
   parameter int unsigned AddrW = 10
) (
   input  logic             i_clk,
   input  logic [AddrW-1:0] rd_addr_i,
   output logic [31:0]      rd_data_o,
   input  logic             wr_en_i,
   input  logic [AddrW-1:0] wr_addr_i,
   input  logic [3:0]       wr_be_i,
   input  logic [31:0]      wr_data_i
);

   logic [31:0] mem_q [Depth];
   logic [31:0] rd_data_q;

   // Registered read plus byte-masked write.
   always_ff @(posedge i_clk) begin
      rd_data_q <= mem_q[rd_addr_i];
      if (wr_en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
               mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
         end
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/zap_wb_slave_mem.sv
// Wishbone slave memory with programmable wait states, incrementing bursts driven
// by an internal address predictor, and error beats for misaligned/out-of-range
// addresses.
module zap_wb_slave_mem
   import zap_wb_slave_mem_pkg::*;
#(
   parameter logic [31:0] DEPTH_WORDS = 32'd1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter logic [31:0] WAIT_STATES = 32'd1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_wen,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [2:0]  i_wb_cti,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_wb_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   zap_wb_state_e state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   adr_q, adr_d;
   logic          mis_q, mis_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;

   logic          req;
   logic [31:0]   next_adr;
   logic [31:0]   rd_adr;
   logic [31:0]   rd_off;
   logic [31:0]   wr_off;
   logic          wr_en;
   logic [31:0]   rd_data;

   assign req      = i_wb_cyc & i_wb_stb;
   assign next_adr = adr_q + 32'd4;

   // Next-state, ack/err of the coming beat and the RAM read address. The RAM
   // read is issued one cycle ahead so data lands together with ack.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      mis_d   = mis_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rd_adr  = adr_q;
      unique case (state_q)
         StIdle: begin
            rd_adr = i_wb_adr;
            if (req) begin
               adr_d = i_wb_adr;
               mis_d = (i_wb_adr[1:0] != 2'b00);
               if (WAIT_STATES == 32'd0) begin
                  // Zero-length wait: ack directly in the next cycle.
                  state_d = StAck;
                  ack_d   = 1'b1;
                  err_d   = (i_wb_adr[1:0] != 2'b00) |
                            addr_out_of_range(i_wb_adr, BASE_ADDR, DEPTH_WORDS);
               end else begin
                  state_d = StWait;
                  cnt_d   = WAIT_STATES[3:0];
               end
            end
         end
         StWait: begin
            if (!req) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = StAck;
                  ack_d   = 1'b1;
                  err_d   = mis_q | addr_out_of_range(adr_q, BASE_ADDR, DEPTH_WORDS);
               end
            end
         end
         StAck, StBurst: begin
            rd_adr = next_adr;
            if (req && (i_wb_cti == CTI_BURST)) begin
               state_d = StBurst;
               adr_d   = next_adr;
               ack_d   = 1'b1;
               err_d   = mis_q | addr_out_of_range(next_adr, BASE_ADDR, DEPTH_WORDS);
            end else begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // FSM and beat registers; synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         adr_q   <= 32'd0;
         mis_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         mis_q   <= mis_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // The write commits at the edge closing a good ack cycle; reset cancels it.
   assign wr_en  = ack_q & ~err_q & i_wb_wen & req & ~i_reset;
   assign rd_off = rd_adr - BASE_ADDR;
   assign wr_off = adr_q - BASE_ADDR;

   logic unused_off;
   assign unused_off = ^{rd_off[31:AW+2], rd_off[1:0], wr_off[31:AW+2], wr_off[1:0]};

   zap_be_ram #(
      .Depth (int'(DEPTH_WORDS)),
      .AddrW (AW)
   ) u_ram (
      .i_clk     (i_clk),
      .rd_addr_i (rd_off[AW+1:2]),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_off[AW+1:2]),
      .wr_be_i   (i_wb_sel),
      .wr_data_i (i_wb_dat)
   );

   assign o_wb_ack = ack_q;
   assign o_wb_err = err_q;
   assign o_wb_dat = (ack_q && !err_q) ? rd_data : 32'd0;

endmodule

// File: tb/tb_zap_wb_slave_mem.sv
// Bench for zap_wb_slave_mem: four instances with different wait states / base
// addresses, driven one at a time, checked against a word-array memory model.
module tb_zap_wb_slave_mem;
   import zap_wb_slave_mem_pkg::*;

   localparam int NDUT = 4;
   localparam logic [31:0] WS [NDUT] = '{32'd2, 32'd1, 32'd3, 32'd0};
   localparam logic [31:0] BA [NDUT] = '{32'h0, 32'h0, 32'h0, 32'h1000};

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc [NDUT];
   logic        stb, wen;
   logic [3:0]  sel;
   logic [31:0] adr, dat_i;
   logic [2:0]  cti;
   logic        ack [NDUT];
   logic        err [NDUT];
   logic [31:0] dat_o [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      zap_wb_slave_mem #(
         .DEPTH_WORDS (32'd1024),
         .BASE_ADDR   (BA[g]),
         .WAIT_STATES (WS[g])
      ) u_dut (
         .i_clk    (clk),
         .i_reset  (rst),
         .i_wb_cyc (cyc[g]),
         .i_wb_stb (stb),
         .i_wb_wen (wen),
         .i_wb_sel (sel),
         .i_wb_adr (adr),
         .i_wb_dat (dat_i),
         .i_wb_cti (cti),
         .o_wb_dat (dat_o[g]),
         .o_wb_ack (ack[g]),
         .o_wb_err (err[g])
      );
   end

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] mm [NDUT][1024];
   bit          known [NDUT][1024];
   logic [31:0] wd [4];
   logic [3:0]  ws [4];
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_err(input int k, input logic [31:0] a, input bit mis);
      logic [31:0] off;
      off = a - BA[k];
      return mis || (a < BA[k]) || ((off >> 2) >= 32'd1024);
   endfunction

   function automatic int m_idx(input int k, input logic [31:0] a);
      return int'((a - BA[k]) >> 2);
   endfunction

   task automatic mwrite(input int k, input int w, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) mm[k][w][8*b +: 8] = d[8*b +: 8];
      if (s == 4'hF) known[k][w] = 1'b1;
   endtask

   // One transfer of n beats (n==1 classic); rst_beat >= 0 asserts reset in that ack cycle.
   task automatic xfer(input int k, input logic [31:0] start, input int n, input bit we,
                       input int rst_beat);
      logic [31:0] a;
      bit          mis, e, stop;
      int          w;
      mis  = (start[1:0] != 2'b00);
      stop = 1'b0;
      @(negedge clk);
      cyc[k] = 1'b1; stb = 1'b1; wen = we; adr = start; dat_i = wd[0]; sel = ws[0];
      cti = (n == 1) ? CTI_CLASSIC : CTI_BURST;
      for (int i = 0; i < int'(WS[k]); i++) begin
         @(negedge clk);
         chk("wait_no_ack", 32'(ack[k]), 32'd0);
      end
      for (int b = 0; b < n && !stop; b++) begin
         a = start + 32'(4 * b);
         e = m_err(k, a, mis);
         w = m_idx(k, a);
         @(negedge clk);
         chk("beat_ack", 32'(ack[k]), 32'd1);
         chk("beat_err", 32'(err[k]), 32'(e));
         if (e) chk("err_dat_zero", dat_o[k], 32'd0);
         else if (!we && known[k][w]) chk("rd_dat", dat_o[k], mm[k][w]);
         last_rd = dat_o[k];
         adr = a; dat_i = wd[b]; sel = ws[b];
         cti = (b < n - 1) ? CTI_BURST : ((n == 1) ? CTI_CLASSIC : CTI_EOB);
         if (b == rst_beat) begin
            rst  = 1'b1;
            stop = 1'b1;
         end else if (we && !e) begin
            mwrite(k, w, wd[b], ws[b]);
         end
      end
      @(negedge clk);
      chk("ack_low_after", 32'(ack[k]), 32'd0);
      cyc[k] = 1'b0; stb = 1'b0; rst = 1'b0;
   endtask

   task automatic rand_wd(input bit full);
      for (int i = 0; i < 4; i++) begin
         wd[i] = $urandom;
         ws[i] = full ? 4'hF : 4'($urandom_range(0, 15));
      end
   endtask

   initial begin
      logic [31:0] st;
      int          len;
      bit          we_r;
      for (int k = 0; k < NDUT; k++) cyc[k] = 1'b0;
      stb = 0; wen = 0; sel = 0; adr = 0; dat_i = 0; cti = CTI_CLASSIC; rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_ack", 32'(ack[k]), 32'd0);
         chk("rst_err", 32'(err[k]), 32'd0);
         chk("rst_dat", dat_o[k], 32'd0);
      end
      rst = 1'b0;

      // cyc low: stb must be ignored
      @(negedge clk);
      stb = 1'b1; adr = 32'h10;
      repeat (4) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) chk("cyc0_no_ack", 32'(ack[k]), 32'd0);
      end
      stb = 1'b0;

      // classic read with two wait states
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      xfer(0, 32'h10, 1, 1'b1, -1);
      xfer(0, 32'h10, 1, 1'b0, -1);
      chk("classic_read_const", last_rd, 32'hDEADBEEF);

      // byte-lane write
      wd[0] = 32'hAAAAAAAA; ws[0] = 4'hF;
      xfer(0, 32'h20, 1, 1'b1, -1);
      wd[0] = 32'h11223344; ws[0] = 4'b0101;
      xfer(0, 32'h20, 1, 1'b1, -1);
      ws[0] = 4'hF;
      xfer(0, 32'h20, 1, 1'b0, -1);
      chk("sel_merge_const", last_rd, 32'hAA22AA44);

      // misaligned and out-of-range classic reads
      xfer(0, 32'h3, 1, 1'b0, -1);
      xfer(0, 32'h1000, 1, 1'b0, -1);

      // burst across the top of memory must not wrap to word 0
      rand_wd(1'b1);
      xfer(0, 32'h0, 1, 1'b1, -1);
      xfer(0, 32'hFF8, 2, 1'b1, -1);
      rand_wd(1'b1);
      xfer(0, 32'hFF8, 4, 1'b1, -1);
      xfer(0, 32'hFF8, 4, 1'b0, -1);
      xfer(0, 32'h0, 1, 1'b0, -1);

      // one wait state: 4-beat incrementing read from 0
      rand_wd(1'b1);
      xfer(1, 32'h0, 4, 1'b1, -1);
      xfer(1, 32'h0, 4, 1'b0, -1);

      // randomized traffic on the bottom and top of memory
      for (int i = 0; i < 4; i++) begin
         rand_wd(1'b1);
         xfer(1, 32'(16 * i), 4, 1'b1, -1);
      end
      for (int i = 0; i < 2; i++) begin
         rand_wd(1'b1);
         xfer(1, 32'hFE0 + 32'(16 * i), 4, 1'b1, -1);
      end
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) st = 32'(4 * $urandom_range(0, 12));
         else st = 32'hFE0 + 32'(4 * $urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) st = st | 32'($urandom_range(1, 3));
         len  = $urandom_range(1, 4);
         we_r = ($urandom_range(0, 1) == 1);
         rand_wd(1'b0);
         xfer(1, st, len, we_r, -1);
      end

      // stb dropped during wait: no ack, no write
      wd[0] = $urandom; ws[0] = 4'hF;
      xfer(2, 32'h40, 1, 1'b1, -1);
      @(negedge clk);
      cyc[2] = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h40; dat_i = ~wd[0]; sel = 4'hF;
      cti = CTI_CLASSIC;
      @(negedge clk);
      stb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_ack", 32'(ack[2]), 32'd0);
      end
      cyc[2] = 1'b0;
      xfer(2, 32'h40, 1, 1'b0, -1);

      // reset in the third beat of a write burst
      rand_wd(1'b1);
      xfer(2, 32'h80, 4, 1'b1, -1);
      rand_wd(1'b1);
      xfer(2, 32'h80, 4, 1'b1, 2);
      xfer(2, 32'h80, 4, 1'b0, -1);
      xfer(2, 32'h40, 1, 1'b0, -1);

      // nonzero base, zero wait states: underflow and top-of-range errors
      xfer(3, 32'h0FFC, 1, 1'b0, -1);
      rand_wd(1'b1);
      xfer(3, 32'h1000, 2, 1'b1, -1);
      xfer(3, 32'h1000, 2, 1'b0, -1);
      xfer(3, 32'h2000, 1, 1'b0, -1);
      xfer(3, 32'h1FFC, 2, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
